// File: rtl/sdram_ctrl_pkg.sv
// Shared types and constants for the SDRAM host sequencer.
// Holds the FSM state encoding and the request entry layout.
package sdram_ctrl_pkg;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 4;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  localparam int REFRESH_PERIOD_DEF = 32;
  localparam int REFRESH_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_RESP,
    S_REFRESH
  } state_t;

  // One queued host request: {we, addr, wdata}
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic req_t pack_req(
    input logic              we,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    req_t r;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/sdram_host_sequencer_4bit_fifo.sv
// Request FIFO for the SDRAM host sequencer.
// Pointers carry one wrap bit to tell full from empty.
module sdram_req_fifo
  import sdram_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  req_t din,
  input  logic pop,
  output logic full,
  output logic empty,
  output req_t head
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  req_t        mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full FIFO refuses a push even when a pop lands in the same cycle
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer update, wrapping modulo the depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/sdram_host_sequencer_4bit.sv
// Host-side sequencer for the 16x4 SDRAM block.
// Queues requests, issues one access at a time, inserts refresh.
module sdram_host_sequencer_4bit
  import sdram_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int REFRESH_PERIOD = REFRESH_PERIOD_DEF,
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              refresh_active
);

  localparam int RP_W = $clog2(REFRESH_PERIOD + 1);
  localparam int RC_W = $clog2(REFRESH_CYCLES + 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REFRESH_PERIOD - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_ONE  = RP_W'(1);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);

  state_t state;
  state_t state_nx;

  req_t req_in;
  req_t head;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;

  logic [RP_W-1:0] ref_cnt;
  logic [RC_W-1:0] ref_win;
  logic            refresh_due;
  logic            ref_start;
  logic            ref_last;

  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_din_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;

  assign req_in    = pack_req(req_we, req_addr, req_wdata);
  assign req_ready = ~fifo_full;

  sdram_req_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .din   (req_in),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  assign refresh_active = (state == S_REFRESH);
  assign ref_last       = (ref_win == RC_LAST);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a due refresh wins over queued work
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (refresh_due) begin
          state_nx = S_REFRESH;
        end else if (!fifo_empty) begin
          state_nx = head.we ? S_WRITE : S_READ;
        end
      end
      S_WRITE:   state_nx = S_IDLE;
      S_READ:    state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_nx = S_IDLE;
      end
      S_REFRESH: begin
        if (ref_last) state_nx = S_IDLE;
      end
      default:   state_nx = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered memory/response outputs
  always_comb begin
    fifo_pop    = 1'b0;
    ref_start   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_din_d   = mem_din;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    unique case (state)
      S_IDLE: begin
        if (refresh_due) begin
          ref_start = 1'b1;
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          mem_addr_d = head.addr;
          if (head.we) begin
            mem_we_d  = 1'b1;
            mem_din_d = head.wdata;
          end
        end
      end
      S_CAPTURE: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mem_dout;
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Registered memory port and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_din   <= mem_din_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  // Refresh interval counter; frozen during a window, cleared on entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
    end else if (ref_start) begin
      ref_cnt <= '0;
    end else if (state != S_REFRESH) begin
      if (ref_cnt == RP_LAST) begin
        ref_cnt <= '0;
      end else begin
        ref_cnt <= ref_cnt + RP_ONE;
      end
    end
  end

  // Sticky refresh request, retired when the window closes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_due <= 1'b0;
    end else if (state == S_REFRESH) begin
      if (ref_last) refresh_due <= 1'b0;
    end else if (ref_cnt == RP_LAST) begin
      refresh_due <= 1'b1;
    end
  end

  // Length of the current refresh window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_win <= '0;
    end else if (state == S_REFRESH) begin
      ref_win <= ref_win + RC_ONE;
    end else begin
      ref_win <= '0;
    end
  end

endmodule

// File: tb/tb_sdram_host_sequencer_4bit.sv
// Directed bench for the SDRAM host sequencer.
// Includes a 16x4 memory with registered read data.
module tb_sdram_host_sequencer_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_rdata;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [3:0] mem_din;
  logic [3:0] mem_dout;
  logic       refresh_active;

  int checks = 0;
  int errors = 0;

  logic [3:0] mem_m [16];

  int   we_pulses = 0;
  int   we_long = 0;
  int   we_in_ref = 0;
  logic we_prev = 1'b0;

  always #5 clk = ~clk;

  sdram_host_sequencer_4bit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .refresh_active (refresh_active)
  );

  always @(posedge clk) begin
    if (mem_we) mem_m[mem_addr] <= mem_din;
    mem_dout <= mem_m[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) begin
      we_pulses++;
      if (we_prev) we_long++;
      if (refresh_active) we_in_ref++;
    end
    we_prev = mem_we;
  end

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic we, input logic [3:0] a,
                      input logic [3:0] d);
    int n;
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL push_timeout addr=%0d got ready=%0b want 1",
               a, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [3:0] d, output bit ok);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = rsp_valid;
    d = rsp_rdata;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_req_ready got %b want 1", req_ready);
    end
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_mem_we got %b want 0", mem_we);
    end
    checks++;
    if (mem_addr !== 4'h0) begin
      errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr);
    end
    checks++;
    if (mem_din !== 4'h0) begin
      errors++; $display("FAIL rst_mem_din got %h want 0", mem_din);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid);
    end
    checks++;
    if (rsp_rdata !== 4'h0) begin
      errors++; $display("FAIL rst_rsp_rdata got %h want 0", rsp_rdata);
    end
    checks++;
    if (refresh_active !== 1'b0) begin
      errors++; $display("FAIL rst_refresh got %b want 0", refresh_active);
    end
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 4'hA;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL wr_e0_we got %b want 0", mem_we);
    end
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 4'd3 || mem_din !== 4'hA) begin
      errors++;
      $display("FAIL wr_e1 got we=%b a=%h d=%h want we=1 a=3 d=a",
               mem_we, mem_addr, mem_din);
    end
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL wr_e2_we got %b want 0", mem_we);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3; req_wdata = 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rd_e2_valid got %b want 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 4'hA) begin
      errors++;
      $display("FAIL rd_e3 got v=%b d=%h want v=1 d=a",
               rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rd_accept got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_fifo_full();
    logic [3:0] addrs [5];
    logic [3:0] exp [5];
    logic [3:0] d;
    bit ok;
    addrs = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd7};
    exp   = '{4'hE, 4'hD, 4'hB, 4'h9, 4'h8};
    for (int i = 0; i < 5; i++) push(1'b1, addrs[i], exp[i]);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 5; i++) push(1'b0, addrs[i], 4'h0);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready got %b want 0", req_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL full_hold got %b want 0", req_ready);
    end
    for (int i = 0; i < 5; i++) begin
      get_rsp(d, ok);
      checks++;
      if (!ok || d !== exp[i]) begin
        errors++;
        $display("FAIL full_rsp%0d got ok=%0b d=%h want ok=1 d=%h",
                 i, ok, d, exp[i]);
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL full_extra got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_addr_wrap();
    logic [3:0] d;
    bit ok;
    push(1'b1, 4'd15, 4'h5);
    push(1'b1, 4'd0, 4'h9);
    push(1'b0, 4'd15, 4'h0);
    get_rsp(d, ok);
    checks++;
    if (!ok || d !== 4'h5) begin
      errors++; $display("FAIL wrap_a15 got ok=%0b d=%h want 5", ok, d);
    end
    push(1'b0, 4'd0, 4'h0);
    get_rsp(d, ok);
    checks++;
    if (!ok || d !== 4'h9) begin
      errors++; $display("FAIL wrap_a0 got ok=%0b d=%h want 9", ok, d);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int snap;
    bit stable;
    push(1'b1, 4'd9, 4'h3);
    push(1'b0, 4'd9, 4'h0);
    push(1'b1, 4'd10, 4'h7);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++; $display("FAIL bp_rsp_timeout got v=0 want 1");
    end
    snap = we_pulses;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== 4'h3) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_stable got v=%b d=%h want v=1 d=3",
               rsp_valid, rsp_rdata);
    end
    checks++;
    if (we_pulses != snap) begin
      errors++;
      $display("FAIL bp_no_issue got %0d writes want %0d", we_pulses, snap);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (we_pulses != snap + 1) begin
      errors++;
      $display("FAIL bp_after got %0d writes want %0d",
               we_pulses, snap + 1);
    end
  endtask

  task automatic test_refresh();
    logic       ra [71];
    logic       ws [71];
    logic [3:0] ad [71];
    logic [3:0] dn [71];
    do_reset();
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      ra[k] = refresh_active;
      ws[k] = mem_we;
      ad[k] = mem_addr;
      dn[k] = mem_din;
      if (k == 31) begin
        req_valid = 1'b1; req_we = 1'b1;
        req_addr = 4'hC; req_wdata = 4'h6;
      end
      if (k == 32) req_valid = 1'b0;
    end
    checks++;
    if (ra[32] !== 1'b0 || ra[33] !== 1'b1 ||
        ra[34] !== 1'b1 || ra[35] !== 1'b0) begin
      errors++;
      $display("FAIL ref1_window got %b%b%b%b want 0110",
               ra[32], ra[33], ra[34], ra[35]);
    end
    checks++;
    if (ws[33] !== 1'b0 || ws[34] !== 1'b0 || ws[35] !== 1'b0) begin
      errors++;
      $display("FAIL ref1_no_we got %b%b%b want 000",
               ws[33], ws[34], ws[35]);
    end
    checks++;
    if (ws[36] !== 1'b1 || ad[36] !== 4'hC || dn[36] !== 4'h6) begin
      errors++;
      $display("FAIL ref1_queued got we=%b a=%h d=%h want we=1 a=c d=6",
               ws[36], ad[36], dn[36]);
    end
    checks++;
    if (ra[67] !== 1'b0 || ra[68] !== 1'b1 ||
        ra[69] !== 1'b1 || ra[70] !== 1'b0) begin
      errors++;
      $display("FAIL ref2_window got %b%b%b%b want 0110",
               ra[67], ra[68], ra[69], ra[70]);
    end
    checks++;
    if (we_in_ref != 0) begin
      errors++; $display("FAIL ref_we_overlap got %0d want 0", we_in_ref);
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    int snap;
    push(1'b1, 4'd12, 4'h1);
    push(1'b1, 4'd13, 4'h2);
    n = 0;
    while (!(mem_we && mem_addr == 4'd12) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_we !== 1'b1) begin
      errors++; $display("FAIL mid_in_write got we=%b want 1", mem_we);
    end
    rst = 1'b1;
    #1;
    snap = we_pulses;
    checks++;
    if (mem_we !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got we=%b rdy=%b v=%b want 0 1 0",
               mem_we, req_ready, rsp_valid);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (we_pulses != snap) begin
      errors++;
      $display("FAIL mid_fifo_empty got %0d writes want %0d",
               we_pulses, snap);
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got rdy=%b v=%b want 1 0",
               req_ready, rsp_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = 4'h0;
    test_reset();
    test_write_read();
    test_fifo_full();
    test_addr_wrap();
    test_backpressure();
    test_refresh();
    test_reset_mid_write();
    checks++;
    if (we_long != 0) begin
      errors++; $display("FAIL we_single_cycle got %0d want 0", we_long);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
